// File: rtl/alu_if.sv
// Operand/result bundle for the ALU: requester drives operands, ALU drives result and flags.
interface alu_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       sel;
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             carry;
  logic             zero;
  logic             overflow;

  modport master (
    output A, B, sel, in_valid,
    input  result, out_valid, carry, zero, overflow
  );

  modport slave (
    input  A, B, sel, in_valid,
    output result, out_valid, carry, zero, overflow
  );
endinterface

// File: rtl/alu.sv
// Registered 8-op ALU; 1-cycle latency, one result per cycle, no backpressure (always ready).
// Flags carry/zero/overflow exist only when ALU_FLAGS_EN is defined, else tied to 0.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] result_d, result_q;
  logic             out_valid_q;

  always_comb begin
    result_d = '0;
    case (bus.sel)
      3'b000:  result_d = bus.A + bus.B;
      3'b001:  result_d = bus.A - bus.B;
      3'b010:  result_d = bus.A & bus.B;
      3'b011:  result_d = bus.A | bus.B;
      3'b100:  result_d = ~bus.A;
      3'b101:  result_d = bus.A ^ bus.B;
      3'b110:  result_d = {bus.A[MSB-1:0], 1'b0};
      3'b111:  result_d = {1'b0, bus.A[MSB:1]};
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) result_q <= result_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum_w, diff_w;
  logic           carry_d, carry_q;
  logic           ovf_d, ovf_q;
  logic           zero_d, zero_q;

  // Extra MSB of the widened add/sub is carry-out resp. borrow.
  assign sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_w = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (bus.sel)
      3'b000: begin
        carry_d = sum_w[WIDTH];
        ovf_d   = (bus.A[MSB] == bus.B[MSB]) && (result_d[MSB] != bus.A[MSB]);
      end
      3'b001: begin
        carry_d = diff_w[WIDTH];
        ovf_d   = (bus.A[MSB] != bus.B[MSB]) && (result_d[MSB] != bus.A[MSB]);
      end
      3'b110:  carry_d = bus.A[MSB];
      3'b111:  carry_d = bus.A[0];
      default: begin
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else if (bus.in_valid) begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.carry    = carry_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
`else
  assign bus.carry    = 1'b0;
  assign bus.zero     = 1'b0;
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_alu.sv
// Bench for alu (WIDTH=4): directed vector table, reset/hold sequences, random vs. arithmetic model.
module tb_alu;
  localparam int W = 4;
`ifdef ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  alu_if #(.WIDTH(W)) bus ();
  alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } vec_t;

  vec_t vt [15];

  // Model state: last registered result/flags.
  int m_res;
  bit m_c, m_z, m_v;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic vld);
    @(negedge clk);
    bus.sel = s; bus.A = a; bus.B = b; bus.in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int res, input bit ov, input bit c,
                          input bit z, input bit v);
    chk({tag, ".result"}, int'(bus.result), res);
    chk({tag, ".out_valid"}, int'(bus.out_valid), int'(ov));
    chk({tag, ".carry"}, int'(bus.carry), int'(FLAGS & c));
    chk({tag, ".zero"}, int'(bus.zero), int'(FLAGS & z));
    chk({tag, ".overflow"}, int'(bus.overflow), int'(FLAGS & v));
  endtask

  // Reference computed from integer arithmetic and signed ranges.
  task automatic model(input logic [2:0] s, input int a, input int b);
    int sa, sb, full, sr;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    m_c = 0; m_v = 0;
    case (s)
      3'd0: begin full = a + b; m_c = (full >= 16); sr = sa + sb; m_v = (sr > 7 || sr < -8); end
      3'd1: begin full = a - b; m_c = (a < b); sr = sa - sb; m_v = (sr > 7 || sr < -8); end
      3'd2: full = a & b;
      3'd3: full = a | b;
      3'd4: full = 15 - a;
      3'd5: full = a ^ b;
      3'd6: begin full = a * 2; m_c = (a >= 8); end
      default: begin full = a / 2; m_c = (a % 2 == 1); end
    endcase
    m_res = ((full % 16) + 16) % 16;
    m_z = (m_res == 0);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    //        sel     a        b        res      c     z     v
    vt[0]  = {3'b000, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b1};
    vt[1]  = {3'b001, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0};
    vt[2]  = {3'b010, 4'b0101, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0};
    vt[3]  = {3'b011, 4'b0101, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b0};
    vt[4]  = {3'b100, 4'b0101, 4'b0011, 4'b1010, 1'b0, 1'b0, 1'b0};
    vt[5]  = {3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0};
    vt[6]  = {3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1};
    vt[7]  = {3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0};
    vt[8]  = {3'b110, 4'b1001, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0};
    vt[9]  = {3'b111, 4'b1001, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0};
    vt[10] = {3'b101, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0};
    vt[11] = {3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1};
    vt[12] = {3'b010, 4'b1100, 4'b0011, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[13] = {3'b111, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0};
    vt[14] = {3'b100, 4'b1111, 4'b0110, 4'b0000, 1'b0, 1'b1, 1'b0};

    bus.A = '0; bus.B = '0; bus.sel = '0; bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_outs("reset", 0, 0, 0, 1, 0);
    #13 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].sel, vt[i].a, vt[i].b, 1'b1);
      chk_outs($sformatf("vec%0d", i), int'(vt[i].res), 1, vt[i].c, vt[i].z, vt[i].v);
    end

    // One valid pulse then two idle cycles: result and flags hold.
    drive(3'b000, 4'b0001, 4'b0001, 1'b1);
    chk_outs("pulse0", 2, 1, 0, 0, 0);
    drive(3'b011, 4'b1111, 4'b1111, 1'b0);
    chk_outs("pulse1", 2, 0, 0, 0, 0);
    drive(3'b001, 4'b0000, 4'b0001, 1'b0);
    chk_outs("pulse2", 2, 0, 0, 0, 0);

    // Mid-cycle reset after a valid op clears outputs before the next edge.
    drive(3'b000, 4'b1111, 4'b0001, 1'b1);
    chk_outs("pre_rst", 0, 1, 1, 1, 0);
    drive(3'b101, 4'b0110, 4'b0000, 1'b1);
    chk_outs("pre_rst2", 6, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 0, 1, 0);
    // in_valid still high across edges while held in reset: nothing captured.
    @(posedge clk); #1;
    chk_outs("in_rst", 0, 0, 0, 1, 0);
    @(negedge clk); rst_n = 1'b1;
    bus.sel = 3'b011; bus.A = 4'b1000; bus.B = 4'b0001; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk_outs("post_rst", 9, 1, 0, 0, 0);

    // Random traffic against the arithmetic model.
    m_res = 9; m_c = 0; m_z = 0; m_v = 0;
    for (int n = 0; n < 300; n++) begin
      logic [2:0]   s;
      logic [W-1:0] a, b;
      logic         vld;
      s   = 3'($urandom_range(0, 7));
      a   = W'($urandom_range(0, 15));
      b   = W'($urandom_range(0, 15));
      vld = ($urandom_range(0, 3) != 0);
      if (vld) model(s, int'(a), int'(b));
      drive(s, a, b, vld);
      chk_outs($sformatf("rnd%0d", n), m_res, vld, m_c, m_z, m_v);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary expected summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; SHALL support any value 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B.
REQ-006 sel  input  3  operation select.
REQ-007 in_valid  input  1  operands/sel valid this cycle.
REQ-008 result  output  WIDTH  registered operation result.
REQ-009 out_valid  output  1  result holds a new value this cycle.
REQ-010 carry  output  1  registered carry/borrow/shift-out flag.
REQ-011 zero  output  1  registered flag, result == 0.
REQ-012 overflow  output  1  registered signed-overflow flag (ADD/SUB only).

Function
REQ-013 Op map SHALL be: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 NOT A (bitwise ~A, B ignored); 101 XOR; 110 SHL A by 1 (LSB 0); 111 SHR A by 1 logical (MSB 0).
REQ-014 Arithmetic SHALL be modulo 2^WIDTH; result truncated to WIDTH bits, no saturation.
REQ-015 Latency SHALL be exactly 1 cycle: a rising edge with in_valid=1 loads result/flags and sets out_valid=1 for the following cycle.
REQ-016 Edge with in_valid=0 SHALL hold result and flags unchanged and drive out_valid=0.
REQ-017 Back-to-back in_valid SHALL give one result per cycle, no stalls, no backpressure.
REQ-018 carry: ADD = carry out of MSB; SUB = borrow (1 when A<B unsigned); SHL = old A[MSB]; SHR = old A[0]; logic ops = 0.
REQ-019 overflow: ADD = operands same sign and result sign differs; SUB = operand signs differ and result sign differs from A; all other ops = 0.
REQ-020 zero SHALL reflect the newly registered result for every op.
REQ-021 Combinational path SHALL have no latches; all 8 sel codes decoded, no default-X.

Reset
REQ-022 rst_n low SHALL immediately clear result, out_valid, carry, zero to 0 except zero=1 (result is 0), and overflow=0, independent of clk.
REQ-023 Reset asserted mid-stream SHALL discard any in-flight operation; first valid output after release is from the first in_valid edge after release.
REQ-024 Reset release SHALL take effect on the next rising clk edge; no operation captured while rst_n=0.

Configuration
REQ-025 Macro ALU_FLAGS_EN: when defined, carry, zero, overflow SHALL behave per REQ-018..020.
REQ-026 When ALU_FLAGS_EN undefined, carry, zero, overflow SHALL be tied to 0 constantly (ports retained) and no flag logic synthesized; result/out_valid unchanged.

Verification
REQ-027 WIDTH=4, A=0101, B=0011, in_valid=1, sel 000..100 in turn -> result 1000, 0010, 0001, 0111, 1010 each one cycle later, out_valid=1.
REQ-028 ADD A=1111, B=0001 -> result 0000, carry=1, zero=1, overflow=0; ADD A=0111, B=0001 -> result 1000, overflow=1, carry=0.
REQ-029 SUB A=0011, B=0101 -> result 1110, carry=1; SHL A=1001 -> 0010, carry=1; SHR A=1001 -> 0100, carry=1; XOR A=1100, B=1010 -> 0110.
REQ-030 in_valid pulses 1,0,0 with sel=000, A=0001, B=0001 -> out_valid 1 then 0,0; result stays 0010 throughout.
REQ-031 Assert rst_n=0 between clock edges after a valid op -> result=0, zero=1, out_valid=0 immediately, before next edge.
REQ-032 Build without ALU_FLAGS_EN, repeat REQ-028 -> results identical, carry/zero/overflow all 0.
